// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub issue stage.
//   ADDSUB_W      default operand/result width
//   OP_ADD/OP_SUB encoding of the mode bit
//   addsub_resp_t one result entry: {result, carry, borrow, ovf, zero}
package addsub_pkg;

    localparam int unsigned ADDSUB_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [ADDSUB_W-1:0] result;
        logic                carry;
        logic                borrow;
        logic                ovf;
        logic                zero;
    } addsub_resp_t;

endpackage

// File: rtl/addsub_issue_stage_if.sv
// Request/response handshake bundle of the add/sub issue stage.
//   in_valid/in_ready        request handshake
//   in_a/in_b/in_mode        operands and mode (0 = add, 1 = subtract)
//   out_valid/out_ready      response handshake (FIFO head)
//   out_result/out_carry/out_borrow/out_ovf/out_zero  head entry contents
// master: producer of requests / consumer of responses. slave: the stage.
interface addsub_issue_stage_if #(
    parameter int unsigned WIDTH = addsub_pkg::ADDSUB_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_borrow;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_borrow, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_borrow, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_core.sv
// Combinational two's-complement add/sub datapath.
//   a, b   operands
//   mode   OP_ADD or OP_SUB
//   resp   {result, carry, borrow, ovf, zero}
// carry is only meaningful for add and borrow only for subtract; the other is forced to 0.
module addsub_core
    import addsub_pkg::*;
(
    input  logic [ADDSUB_W-1:0] a,
    input  logic [ADDSUB_W-1:0] b,
    input  logic                mode,
    output addsub_resp_t        resp
);
    localparam int unsigned W = ADDSUB_W;

    logic [W-1:0] bm;
    logic [W-1:0] r;
    logic [W:0]   usum;

    always_comb begin
        bm   = (mode == OP_SUB) ? (~b + W'(1)) : b;
        r    = a + bm;
        usum = {1'b0, a} + {1'b0, b};

        resp.result = r;
        resp.carry  = (mode == OP_ADD) && usum[W];
        resp.borrow = (mode == OP_SUB) && (a < b);
        if (mode == OP_ADD) begin
            resp.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            resp.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        resp.zero = (r == '0);
    end
endmodule

// File: rtl/addsub_issue_stage.sv
// Pipelined, flow-controlled add/sub stage: an operand register (S1) feeding the
// combinational core, whose response is pushed into a small output FIFO.
// Latency 2 cycles, throughput 1 op/cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear of S1 and FIFO (op_count kept)
//   bus         slave side of addsub_issue_stage_if (requests in, responses out)
//   op_count    number of output handshakes, wrapping
module addsub_issue_stage
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_W,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    addsub_issue_stage_if.slave    bus,
    output logic [CNT_W-1:0]       op_count
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_mode_q;

    addsub_resp_t     core_resp;
    addsub_resp_t     mem_q [DEPTH];
    addsub_resp_t     last_q;
    addsub_resp_t     head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fifo_cnt_q;
    logic [CNT_W-1:0] op_count_q;

    logic fifo_full, out_valid, pop, push, s1_adv, accept, in_ready;

    addsub_core u_core (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .mode (s1_mode_q),
        .resp (core_resp)
    );

    always_comb begin
        fifo_full = (fifo_cnt_q == FCNT_W'(DEPTH));
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid && bus.out_ready && !flush;
        // A full FIFO can still take the S1 entry when the head leaves this cycle.
        s1_adv    = s1_valid_q && (!fifo_full || pop);
        push      = s1_adv && !flush;
        in_ready  = rst_n && !flush && (!s1_valid_q || s1_adv);
        accept    = bus.in_valid && in_ready;
        head      = mem_q[rd_ptr_q];
    end

    // Operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= OP_ADD;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= bus.in_a;
            s1_b_q     <= bus.in_b;
            s1_mode_q  <= bus.in_mode;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Output FIFO. last_q keeps the most recently popped entry so the outputs
    // hold their last value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            op_count_q <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= core_resp;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                last_q     <= head;
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                op_count_q <= op_count_q + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    addsub_resp_t shown;
    assign shown          = out_valid ? head : last_q;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = shown.result;
    assign bus.out_carry  = shown.carry;
    assign bus.out_borrow = shown.borrow;
    assign bus.out_ovf    = shown.ovf;
    assign bus.out_zero   = shown.zero;
    assign op_count       = op_count_q;
endmodule
